// File: rtl/rv_isa_pkg.sv
// ============================================================================
// Module   : rv_isa_pkg
// Brief    : RV32 opcode, immediate-type and NOP constants for fetch/decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv_isa_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_I    = 2'd1;
    localparam logic [1:0] IMM_S    = 2'd2;
    localparam logic [1:0] IMM_B    = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/imm_field_decode.sv
// ============================================================================
// Module   : imm_field_decode
// Brief    : Combinational 12-bit immediate assembly and legality check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imm_field_decode
    import rv_isa_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [11:0] imm12_o,
    output logic [1:0]  imm_type_o,
    output logic        illegal_o
);

    logic [6:0] w_opcode;
    logic       w_known;

    assign w_opcode = instr_i[6:0];

    always_comb begin
        imm12_o    = 12'd0;
        imm_type_o = IMM_NONE;
        w_known    = 1'b1;
        case (w_opcode)
            OP_IMM, LOAD, JALR: begin
                imm12_o    = instr_i[31:20];
                imm_type_o = IMM_I;
            end
            STORE: begin
                imm12_o    = {instr_i[31:25], instr_i[11:7]};
                imm_type_o = IMM_S;
            end
            // Branch offset bit 0 is implicit; the consumer shifts left by one.
            BRANCH: begin
                imm12_o    = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
                imm_type_o = IMM_B;
            end
            OP, JAL, LUI, AUIPC: w_known = 1'b1;
            default:             w_known = 1'b0;
        endcase
    end

    assign illegal_o = !w_known || (instr_i[1:0] != 2'b11);

endmodule

`default_nettype wire

// File: rtl/if_id_imm_stage.sv
// ============================================================================
// Module   : if_id_imm_stage
// Brief    : Fetch-to-decode stage with 2-entry skid buffer and imm assembly.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_imm_stage
    import rv_isa_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [11:0]     out_imm12,
    output logic [1:0]      out_imm_type,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [11:0]     imm12;
        logic [1:0]      imm_type;
        logic            illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        pc:       RESET_PC,
        instr:    XLEN'(NOP_INSTR),
        imm12:    12'd0,
        imm_type: IMM_NONE,
        illegal:  1'b0
    };

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t w_new;
    logic   w_accept;
    logic   w_pop;

    imm_field_decode u_imm_dec (
        .instr_i    (in_instr[31:0]),
        .imm12_o    (w_new.imm12),
        .imm_type_o (w_new.imm_type),
        .illegal_o  (w_new.illegal)
    );

    assign w_new.pc    = in_pc;
    assign w_new.instr = in_instr;

    // in_ready depends only on the state register, so it is glitch-free.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    head_d  = w_new;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    head_d = w_new;
                end else if (w_accept) begin
                    skid_d  = w_new;
                    state_d = FULL;
                end else if (w_pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Head keeps its last contents on flush so idle outputs stay quiet.
        if (flush) begin
            state_d = EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= RESET_ENTRY;
            skid_q  <= RESET_ENTRY;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_pc       = head_q.pc;
    assign out_instr    = head_q.instr;
    assign out_rd       = head_q.instr[11:7];
    assign out_rs1      = head_q.instr[19:15];
    assign out_rs2      = head_q.instr[24:20];
    assign out_funct3   = head_q.instr[14:12];
    assign out_imm12    = head_q.imm12;
    assign out_imm_type = head_q.imm_type;
    assign out_illegal  = head_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_if_id_imm_stage.sv
// ============================================================================
// Module   : tb_if_id_imm_stage
// Brief    : Directed and randomised self-checking bench for if_id_imm_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_imm_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [11:0] out_imm12;
    logic [1:0]  out_imm_type;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_imm_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct3   (out_funct3),
        .out_imm12    (out_imm12),
        .out_imm_type (out_imm_type),
        .out_illegal  (out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    logic [63:0] sb[$];
    logic [63:0] exp_e;
    logic [31:0] pc_ctr;
    logic        acc, pop;
    int          budget;

    initial begin
        // ---- Reset state ----
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_imm12", 32'(out_imm12), 32'd0);
        chk("rst_imm_type", 32'(out_imm_type), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);

        // ---- 1: single I-type transfer ----
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF0_0093, 32'h0000_0010);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_imm12", 32'(out_imm12), 32'hFFF);
        chk("t1_type", 32'(out_imm_type), 32'd1);
        chk("t1_rd", 32'(out_rd), 32'd1);
        chk("t1_rs1", 32'(out_rs1), 32'd0);
        chk("t1_pc", out_pc, 32'h10);
        chk("t1_illegal", 32'(out_illegal), 32'd0);

        // ---- 2: STORE then BRANCH back-to-back ----
        drive(1'b1, 32'h0020_A423, 32'h0000_0014);
        tick();
        chk("t2_s_imm12", 32'(out_imm12), 32'h008);
        chk("t2_s_type", 32'(out_imm_type), 32'd2);
        chk("t2_s_rs1", 32'(out_rs1), 32'd1);
        chk("t2_s_rs2", 32'(out_rs2), 32'd2);
        chk("t2_s_funct3", 32'(out_funct3), 32'd2);
        drive(1'b1, 32'hFE00_0EE3, 32'h0000_0018);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t2_b_imm12", 32'(out_imm12), 32'hFFE);
        chk("t2_b_type", 32'(out_imm_type), 32'd3);
        chk("t2_b_pc", out_pc, 32'h18);
        tick();
        chk("t2_drained", 32'(out_valid), 32'd0);

        // ---- 3: backpressure with three words ----
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'h100);
        tick();
        chk("t3_ready_one", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h0020_0113, 32'h104);
        tick();
        chk("t3_ready_full", 32'(in_ready), 32'd0);
        chk("t3_head_a", out_instr, 32'h0010_0093);
        drive(1'b1, 32'h0030_0193, 32'h108);
        tick();
        chk("t3_hold_head", out_instr, 32'h0010_0093);
        chk("t3_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t3_head_b", out_instr, 32'h0020_0113);
        chk("t3_head_b_pc", out_pc, 32'h104);
        chk("t3_ready_again", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("t3_head_c", out_instr, 32'h0030_0193);
        chk("t3_c_valid", 32'(out_valid), 32'd1);
        tick();
        chk("t3_empty", 32'(out_valid), 32'd0);

        // ---- 4: flush in FULL with a word offered ----
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'h200);
        tick();
        drive(1'b1, 32'h0020_0113, 32'h204);
        tick();
        chk("t4_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h0040_0213, 32'h208);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("t4_flush_valid", 32'(out_valid), 32'd0);
        chk("t4_flush_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t4_no_ghost", 32'(out_valid), 32'd0);

        // ---- 5: LUI and illegal encodings ----
        out_ready = 1'b1;
        drive(1'b1, 32'h1234_50B7, 32'h300);
        tick();
        chk("t5_lui_imm", 32'(out_imm12), 32'd0);
        chk("t5_lui_type", 32'(out_imm_type), 32'd0);
        chk("t5_lui_illegal", 32'(out_illegal), 32'd0);
        drive(1'b1, 32'h0000_007F, 32'h304);
        tick();
        chk("t5_7f_illegal", 32'(out_illegal), 32'd1);
        chk("t5_7f_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 32'h0000_0090, 32'h308);
        tick();
        chk("t5_90_illegal", 32'(out_illegal), 32'd1);
        chk("t5_90_type", 32'(out_imm_type), 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        tick();

        // ---- 6: reset while FULL with flush and in_valid ----
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'h400);
        tick();
        drive(1'b1, 32'h0020_0113, 32'h404);
        tick();
        rst   = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h0050_0293, 32'h408);
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_pc", out_pc, 32'h0);
        chk("t6_instr", out_instr, 32'h0000_0013);
        chk("t6_ready", 32'(in_ready), 32'd1);

        // ---- Random traffic against an in-order scoreboard ----
        pc_ctr = 32'h1000;
        for (int cyc = 0; cyc < 300; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = $urandom;
            in_pc     = pc_ctr;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("rnd_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    exp_e = sb.pop_front();
                    chk("rnd_instr", out_instr, exp_e[31:0]);
                    chk("rnd_pc", out_pc, exp_e[63:32]);
                end
            end
            if (acc) begin
                sb.push_back({pc_ctr, in_instr});
                pc_ctr = pc_ctr + 32'd4;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 10;
        #1;
        while (out_valid && budget > 0) begin
            if (sb.size() == 0) begin
                chk("drain_unexpected", 32'd1, 32'd0);
            end else begin
                exp_e = sb.pop_front();
                chk("drain_instr", out_instr, exp_e[31:0]);
            end
            tick();
            budget--;
        end
        chk("drain_budget", 32'(budget > 0), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
